// File: rtl/wb_fwd_producer_if.sv
// wb_fwd_producer_if
// Bundles the stage-2 / stage-3 signals exchanged between the pipeline and
// the forwarding producer tracker.
//   master : pipeline side, drives s2_inst/s2_valid/pipe_stall/flush/wb_data
//   slave  : tracker side, drives fwd_sel_rs1/rs2, hist_data, s3_rd, s3_wen,
//            fwd_cnt_s3, fwd_cnt_hist
interface wb_fwd_producer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [31:0]      s2_inst;
    logic             s2_valid;
    logic             pipe_stall;
    logic             flush;
    logic [XLEN-1:0]  wb_data;
    logic [1:0]       fwd_sel_rs1;
    logic [1:0]       fwd_sel_rs2;
    logic [XLEN-1:0]  hist_data;
    logic [4:0]       s3_rd;
    logic             s3_wen;
    logic [CNT_W-1:0] fwd_cnt_s3;
    logic [CNT_W-1:0] fwd_cnt_hist;

    modport master (
        output s2_inst, s2_valid, pipe_stall, flush, wb_data,
        input  fwd_sel_rs1, fwd_sel_rs2, hist_data, s3_rd, s3_wen,
               fwd_cnt_s3, fwd_cnt_hist
    );

    modport slave (
        input  s2_inst, s2_valid, pipe_stall, flush, wb_data,
        output fwd_sel_rs1, fwd_sel_rs2, hist_data, s3_rd, s3_wen,
               fwd_cnt_s3, fwd_cnt_hist
    );
endinterface

// File: rtl/wb_fwd_producer.sv
// wb_fwd_producer
// Tracks the producer in stage 3 and the producer that retired one cycle
// earlier (history), and derives the stage-2 operand forwarding selects.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : synchronous active-low reset, wins over stall and flush
//   bus   : wb_fwd_producer_if.slave
//           in : s2_inst, s2_valid, pipe_stall, flush, wb_data
//           out: fwd_sel_rs1/rs2 (0=regfile, 1=stage-3 wb_data, 2=hist_data),
//                hist_data, s3_rd, s3_wen, fwd_cnt_s3, fwd_cnt_hist
module wb_fwd_producer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_fwd_producer_if.slave  bus
);
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [1:0] SEL_RF   = 2'd0;
    localparam logic [1:0] SEL_S3   = 2'd1;
    localparam logic [1:0] SEL_HIST = 2'd2;

    // Returns {has_rd, uses_rs1, uses_rs2}; unknown opcodes decode as inert.
    function automatic logic [2:0] decode(input logic [6:0] opcode);
        logic [2:0] d;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL:                        d = 3'b100;
            OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM, OP_SYSTEM: d = 3'b110;
            OP_BRANCH, OP_STORE:                             d = 3'b011;
            OP_OP:                                           d = 3'b111;
            default:                                         d = 3'b000;
        endcase
        return d;
    endfunction

    logic             s3_wen_q,    s3_wen_d;
    logic [4:0]       s3_rd_q,     s3_rd_d;
    logic             hist_vld_q,  hist_vld_d;
    logic [4:0]       hist_rd_q,   hist_rd_d;
    logic [XLEN-1:0]  hist_data_q, hist_data_d;
    logic [CNT_W-1:0] cnt_s3_q,    cnt_s3_d;
    logic [CNT_W-1:0] cnt_hist_q,  cnt_hist_d;

    logic [2:0] s2_dec;
    logic [4:0] s2_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] sel_rs1;
    logic [1:0] sel_rs2;
    logic [1:0] n_s3;
    logic [1:0] n_hist;

    always_comb begin
        s2_dec  = decode(bus.s2_inst[6:0]);
        s2_rd   = bus.s2_inst[11:7];
        rs1     = bus.s2_inst[19:15];
        rs2     = bus.s2_inst[24:20];
        sel_rs1 = SEL_RF;
        sel_rs2 = SEL_RF;

        // Stage 3 is the younger producer, so it is tested first.
        if (s2_dec[1] && bus.s2_valid && rs1 != 5'd0) begin
            if (s3_wen_q && rs1 == s3_rd_q) begin
                sel_rs1 = SEL_S3;
            end else if (hist_vld_q && rs1 == hist_rd_q) begin
                sel_rs1 = SEL_HIST;
            end
        end
        if (s2_dec[0] && bus.s2_valid && rs2 != 5'd0) begin
            if (s3_wen_q && rs2 == s3_rd_q) begin
                sel_rs2 = SEL_S3;
            end else if (hist_vld_q && rs2 == hist_rd_q) begin
                sel_rs2 = SEL_HIST;
            end
        end

        n_s3   = {1'b0, sel_rs1 == SEL_S3}   + {1'b0, sel_rs2 == SEL_S3};
        n_hist = {1'b0, sel_rs1 == SEL_HIST} + {1'b0, sel_rs2 == SEL_HIST};
    end

    always_comb begin
        s3_wen_d    = s3_wen_q;
        s3_rd_d     = s3_rd_q;
        hist_vld_d  = hist_vld_q;
        hist_rd_d   = hist_rd_q;
        hist_data_d = hist_data_q;
        cnt_s3_d    = cnt_s3_q;
        cnt_hist_d  = cnt_hist_q;

        if (!bus.pipe_stall) begin
            // The stage-3 entry retires into history even when stage 2 is
            // being flushed; only non-writing entries leave history empty.
            hist_vld_d  = s3_wen_q;
            hist_rd_d   = s3_wen_q ? s3_rd_q : 5'd0;
            hist_data_d = bus.wb_data;

            if (bus.s2_valid && !bus.flush) begin
                s3_rd_d  = s2_dec[2] ? s2_rd : 5'd0;
                s3_wen_d = s2_dec[2] && (s2_rd != 5'd0);
            end else begin
                s3_rd_d  = 5'd0;
                s3_wen_d = 1'b0;
            end

            if (!bus.flush) begin
                cnt_s3_d   = cnt_s3_q   + CNT_W'(n_s3);
                cnt_hist_d = cnt_hist_q + CNT_W'(n_hist);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_wen_q    <= 1'b0;
            s3_rd_q     <= 5'd0;
            hist_vld_q  <= 1'b0;
            hist_rd_q   <= 5'd0;
            hist_data_q <= '0;
            cnt_s3_q    <= '0;
            cnt_hist_q  <= '0;
        end else begin
            s3_wen_q    <= s3_wen_d;
            s3_rd_q     <= s3_rd_d;
            hist_vld_q  <= hist_vld_d;
            hist_rd_q   <= hist_rd_d;
            hist_data_q <= hist_data_d;
            cnt_s3_q    <= cnt_s3_d;
            cnt_hist_q  <= cnt_hist_d;
        end
    end

    assign bus.fwd_sel_rs1  = sel_rs1;
    assign bus.fwd_sel_rs2  = sel_rs2;
    assign bus.hist_data    = hist_data_q;
    assign bus.s3_rd        = s3_rd_q;
    assign bus.s3_wen       = s3_wen_q;
    assign bus.fwd_cnt_s3   = cnt_s3_q;
    assign bus.fwd_cnt_hist = cnt_hist_q;

endmodule

// File: tb/tb_wb_fwd_producer.sv
module tb_wb_fwd_producer;
    logic clk;
    logic rst_n;

    wb_fwd_producer_if #(.XLEN(32), .CNT_W(32)) bus ();

    wb_fwd_producer #(.XLEN(32), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          row;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] hist;
        logic [31:0] c3;
        logic [31:0] ch;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   row_no   = 0;

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
        end
    endtask

    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] i_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] i_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] lo5);
        return {7'b0000000, rs2, rs1, 3'b000, lo5, 7'b1100011};
    endfunction

    function automatic logic [31:0] i_lui(input logic [4:0] rd, input logic [19:0] imm20);
        return {imm20, rd, 7'b0110111};
    endfunction

    // Drive one cycle of inputs just after a rising edge and queue the
    // outputs expected before the next edge.
    task automatic step(input logic rst, input logic [31:0] inst, input logic v,
                        input logic st, input logic fl, input logic [31:0] wbd,
                        input logic [1:0] e1, input logic [1:0] e2,
                        input logic [4:0] erd, input logic ewen,
                        input logic [31:0] eh, input logic [31:0] ec3,
                        input logic [31:0] ech);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rst;
        bus.s2_inst    = inst;
        bus.s2_valid   = v;
        bus.pipe_stall = st;
        bus.flush      = fl;
        bus.wb_data    = wbd;
        row_no++;
        e.row  = row_no;
        e.sel1 = e1;
        e.sel2 = e2;
        e.rd   = erd;
        e.wen  = ewen;
        e.hist = eh;
        e.c3   = ec3;
        e.ch   = ech;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("fwd_sel_rs1", e.row, {30'd0, bus.fwd_sel_rs1}, {30'd0, e.sel1});
            chk("fwd_sel_rs2", e.row, {30'd0, bus.fwd_sel_rs2}, {30'd0, e.sel2});
            chk("s3_rd",       e.row, {27'd0, bus.s3_rd},       {27'd0, e.rd});
            chk("s3_wen",      e.row, {31'd0, bus.s3_wen},      {31'd0, e.wen});
            chk("hist_data",   e.row, bus.hist_data,            e.hist);
            chk("fwd_cnt_s3",  e.row, bus.fwd_cnt_s3,           e.c3);
            chk("fwd_cnt_hist",e.row, bus.fwd_cnt_hist,         e.ch);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] add_665;
        add_665 = i_r(7'h00, 5'd6, 5'd5, 5'd5);

        rst_n          = 1'b0;
        bus.s2_inst    = add_665;
        bus.s2_valid   = 1'b1;
        bus.pipe_stall = 1'b0;
        bus.flush      = 1'b0;
        bus.wb_data    = 32'd0;

        //   rst  inst                          v  st fl wb     s1 s2 rd  wen hist c3  ch
        // Reset held across two edges with a valid consumer present.
        step(0, add_665,                        1, 0, 0, 32'd0,  0, 0, 0,  0, 0,  0,  0);
        // Back-to-back: addi x5 then add x6,x5,x5.
        step(1, i_addi(5, 0, 7),                1, 0, 0, 32'd0,  0, 0, 0,  0, 0,  0,  0);
        step(1, add_665,                        1, 0, 0, 32'd7,  1, 1, 5,  1, 0,  0,  0);
        // Gap of one: addi x5, addi x1, sub x7,x5,x1.
        step(1, i_addi(5, 0, 7),                1, 0, 0, 32'd13, 0, 0, 6,  1, 7,  2,  0);
        step(1, i_addi(1, 0, 1),                1, 0, 0, 32'd7,  0, 0, 5,  1, 13, 2,  0);
        step(1, i_r(7'h20, 7, 5, 1),            1, 0, 0, 32'd1,  2, 1, 1,  1, 7,  2,  0);
        // Priority: x3 in history (9) and in stage 3 (4).
        step(1, i_addi(3, 0, 9),                1, 0, 0, 32'd20, 0, 0, 7,  1, 1,  3,  1);
        step(1, i_addi(3, 0, 4),                1, 0, 0, 32'd9,  0, 0, 3,  1, 20, 3,  1);
        step(1, i_r(7'h00, 8, 3, 0),            1, 0, 0, 32'd4,  1, 0, 3,  1, 9,  3,  1);
        // x0 producer never writes; history x8 still forwards.
        step(1, i_addi(0, 0, 5),                1, 0, 0, 32'd30, 0, 0, 8,  1, 4,  4,  1);
        step(1, i_r(7'h00, 9, 8, 0),            1, 0, 0, 32'd5,  2, 0, 0,  0, 30, 4,  1);
        // Store in stage 3 with rd-field 12 must not forward.
        step(1, i_sw(9, 9, 12'd12),             1, 0, 0, 32'd40, 1, 1, 9,  1, 5,  4,  2);
        step(1, i_r(7'h00, 10, 12, 9),          1, 0, 0, 32'd99, 0, 2, 0,  0, 40, 6,  2);
        // Branch in stage 3 with rd-field 14 must not forward.
        step(1, i_beq(10, 10, 5'd14),           1, 0, 0, 32'd50, 1, 1, 10, 1, 99, 6,  3);
        step(1, i_r(7'h00, 11, 14, 10),         1, 0, 0, 32'd77, 0, 2, 0,  0, 50, 8,  3);
        // LUI consumer whose rs fields alias x11 uses no sources.
        step(1, i_lui(11, 20'h00B58),           1, 0, 0, 32'd60, 0, 0, 11, 1, 77, 8,  4);
        // I-type: rs2 field (imm) equals x11 but is ignored.
        step(1, i_addi(6, 11, 11),              1, 0, 0, 32'd70, 1, 0, 11, 1, 60, 8,  4);
        // Stall for three cycles, then release.
        step(1, i_r(7'h00, 7, 6, 11),           1, 1, 0, 32'd80, 1, 2, 6,  1, 70, 9,  4);
        step(1, i_r(7'h00, 7, 6, 11),           1, 1, 0, 32'd81, 1, 2, 6,  1, 70, 9,  4);
        step(1, i_r(7'h00, 7, 6, 11),           1, 1, 0, 32'd81, 1, 2, 6,  1, 70, 9,  4);
        step(1, i_r(7'h00, 7, 6, 11),           1, 0, 0, 32'd82, 1, 2, 6,  1, 70, 9,  4);
        // Flush: stage 2 squashed, stage 3 still retires, no counting.
        step(1, i_r(7'h00, 6, 7, 6),            1, 0, 1, 32'd90, 1, 2, 7,  1, 82, 10, 5);
        step(1, i_r(7'h00, 6, 7, 7),            1, 0, 0, 32'd0,  2, 2, 0,  0, 90, 10, 5);
        // Bubble in stage 2 never selects.
        step(1, i_r(7'h00, 1, 6, 6),            0, 0, 0, 32'd3,  0, 0, 6,  1, 0,  10, 7);
        // Reset wins over stall and flush.
        step(0, i_r(7'h00, 1, 6, 6),            1, 1, 1, 32'd5,  2, 2, 0,  0, 3,  10, 7);
        step(1, i_r(7'h00, 1, 6, 6),            1, 0, 0, 32'd0,  0, 0, 0,  0, 0,  0,  0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_fwd_producer.md
Name: wb_fwd_producer

Overview:
- Producer-side companion to the stage-2 operand-select logic of the 3-stage RV32I core.
- Tracks the instruction in stage 3 (writeback) and the instruction that retired one cycle earlier. The history entry is needed because stage-2 operands were read from the regfile before that write landed.
- Drives forwarding selects for rs1/rs2, a captured history data word, and forwarding-event counters.

Parameters:
- XLEN, 32, data width of wb_data / hist_data.
- CNT_W, 32, width of forwarding-event counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- s2_inst  input  32  instruction currently in stage 2.
- s2_valid  input  1  s2_inst is a real instruction (0 = bubble).
- pipe_stall  input  1  global stall; freezes all state in this block.
- flush  input  1  branch/jump redirect; stage-2 instruction is squashed.
- wb_data  input  XLEN  writeback value of the instruction this block holds in stage 3; valid the same cycle.
- fwd_sel_rs1  output  2  0=regfile, 1=stage-3 wb_data, 2=hist_data.
- fwd_sel_rs2  output  2  same encoding, for rs2.
- hist_data  output  XLEN  value written by the previously retired producer.
- s3_rd  output  5  rd of stage-3 entry (0 if none).
- s3_wen  output  1  stage-3 entry writes a nonzero rd.
- fwd_cnt_s3  output  CNT_W  count of operands forwarded from stage 3.
- fwd_cnt_hist  output  CNT_W  count of operands forwarded from history.

Behaviour:
- State: stage-3 entry {valid, rd, wen}; history entry {valid, rd, data}; two counters.
- Reset (rst_n=0 at edge): all valid/wen = 0, rd = 0, hist_data = 0, counters = 0.
  - fwd_sel_* = 0 combinationally while state is reset.
  - Reset overrides pipe_stall and flush.
- Decode, applied to any instruction:
  - has_rd = opcode not BRANCH and not STORE; wen = has_rd && rd != 0.
  - uses_rs1 = opcode not LUI, AUIPC or JAL.
  - uses_rs2 = opcode is BRANCH, STORE or R-type (OP).
  - CSR counts as has_rd. Unknown opcodes: has_rd=0, uses_rs1=0, uses_rs2=0.
- Advance (rising edge, rst_n=1, pipe_stall=0):
  - History <= stage-3 entry: valid, rd taken only if stage-3 wen=1, else history.valid=0; data <= wb_data.
  - Stage-3 <= decode(s2_inst) if s2_valid && !flush, else bubble (valid=0, wen=0, rd=0).
  - Flush squashes only the stage-2 instruction; the stage-3 entry still retires into history.
- Stall (pipe_stall=1): stage-3, history and counters hold. Outputs remain a function of held state, current s2_inst and wb_data.
- Select (combinational, per source rsN from s2_inst[19:15] / [24:20]):
  - 1 if uses_rsN && s2_valid && s3_wen && rsN==s3_rd.
  - else 2 if uses_rsN && s2_valid && hist.valid && rsN==hist.rd.
  - else 0.
  - Stage 3 has priority over history (youngest producer wins). rsN==0 always selects 0.
- Counters:
  - On advance with flush=0, fwd_cnt_s3 += number of rs1/rs2 selects equal to 1 (0,1,2). fwd_cnt_hist likewise for selects equal to 2.
  - Counters wrap modulo 2^CNT_W and do not count during stall or flush.
- Latency: selects are 0-cycle (combinational) from s2_inst; producer state is 1 cycle per stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles with s2_valid=1 → s3_wen=0, s3_rd=0, hist_data=0, counters=0, fwd_sel_rs1=fwd_sel_rs2=0.
- Back-to-back: `addi x5,x0,7` then `add x6,x5,x5` with wb_data=7 → fwd_sel_rs1=fwd_sel_rs2=1; after advance fwd_cnt_s3=2.
- Gap of one: `addi x5,x0,7`, `addi x1,x0,1`, `sub x7,x5,x1` → rs1 sel=2 with hist_data=7, rs2 sel=1; fwd_cnt_hist +1, fwd_cnt_s3 +1.
- Priority and x0: history rd=x3 (data 9), stage-3 rd=x3 (wb_data 4), consumer `add x8,x3,x0` → rs1 sel=1, rs2 sel=0. Producer `addi x0,x0,5` → s3_wen=0.
- Non-producers and non-users: a `sw` or `beq` in stage 3 never forwards; `lui x5` in stage 2 with x5 in stage 3 gives both selects 0. `addi x6,x5,1` after `addi x5` gives rs1 sel=1 and rs2 sel=0 (rs2 field ignored for I-type).
- Stall and flush:
  - pipe_stall=1 for 3 cycles → s3_rd, hist_data and counters are unchanged.
  - flush=1 with `add x6,x5,x5` in stage 2 → next cycle s3_wen=0, the old stage-3 entry moves into history, and counters are unchanged.
